// File: rtl/issue_scoreboard.sv
// Issue stage with a single holding register and a register-pending scoreboard.
// A decoded uop is captured, held until its sources/destination are free and EX
// is ready, then issued; issuing a register writer marks its rd pending until
// writeback. Optional stall-cycle counter: define ISSUE_PERF_CNT_EN.

package riscv_uop_pkg;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [31:0] imm;
  } uop_t;

endpackage

module issue_scoreboard
  import riscv_uop_pkg::*;
#(
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dec_valid,
  input  uop_t                  i_uop,
  input  logic [31:0]           i_dec_pc,
  output logic                  o_dec_ready,
  output logic                  o_ex_valid,
  output uop_t                  o_ex_uop,
  output logic [31:0]           o_ex_pc,
  input  logic                  i_ex_ready,
  input  logic                  i_wb_valid,
  input  logic [4:0]            i_wb_rd,
  input  logic                  i_flush,
  output logic                  o_stall_to_dec,
  output logic [31:0]           o_busy_regs
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] o_stall_cnt
`endif
);

  if (PERF_CNT_W < 1) begin : g_bad_width
    $error("PERF_CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e      state_q, state_d;
  uop_t        uop_q, uop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;

  logic        held;
  logic [31:0] rel;
  logic [31:0] eff;
  logic [31:0] set;
  logic        hazard;
  logic        issue;
  logic        accept;

  // Hazard check against pending bits, with same-cycle writeback bypass.
  always_comb begin
    rel    = i_wb_valid ? (32'd1 << i_wb_rd) : 32'd0;
    eff    = pend_q & ~rel;
    held   = (state_q == StHeld);
    hazard = (uop_q.uses_rs1  && (uop_q.rs1 != 5'd0) && eff[uop_q.rs1]) ||
             (uop_q.uses_rs2  && (uop_q.rs2 != 5'd0) && eff[uop_q.rs2]) ||
             (uop_q.writes_rd && (uop_q.rd  != 5'd0) && eff[uop_q.rd]);
    issue  = held && !hazard && i_ex_ready && !i_flush;
  end

  // Handshake and issue outputs; payload is zeroed whenever nothing issues.
  always_comb begin
    o_dec_ready    = !i_flush && (!held || issue);
    accept         = i_dec_valid && o_dec_ready;
    o_stall_to_dec = !o_dec_ready;
    o_ex_valid     = issue;
    o_ex_uop       = issue ? uop_q : '0;
    o_ex_pc        = issue ? pc_q : 32'd0;
    o_busy_regs    = pend_q;
  end

  // Holding-register FSM next state. Invalid uops are accepted but not held.
  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    pc_d    = pc_q;
    if (i_flush) begin
      state_d = StEmpty;
    end else if (accept && i_uop.valid) begin
      state_d = StHeld;
      uop_d   = i_uop;
      pc_d    = i_dec_pc;
    end else if (issue) begin
      state_d = StEmpty;
    end
  end

  // Scoreboard update: release first, then set, so set wins on the same rd.
  always_comb begin
    set = 32'd0;
    if (issue && uop_q.writes_rd && (uop_q.rd != 5'd0)) begin
      set = 32'd1 << uop_q.rd;
    end
    pend_d = (eff | set) & ~32'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      uop_q   <= '0;
      pc_q    <= 32'd0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles a held uop waits (hazard or backpressure), saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (held && !issue && !i_flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus a random
// run checked against a queue/array reference model.

module tb_issue_scoreboard;
  import riscv_uop_pkg::*;

  localparam int unsigned CntW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dec_valid;
  uop_t            uop;
  logic [31:0]     dec_pc;
  logic            dec_ready;
  logic            ex_valid;
  uop_t            ex_uop;
  logic [31:0]     ex_pc;
  logic            ex_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            stall_to_dec;
  logic [31:0]     busy_regs;
`ifdef ISSUE_PERF_CNT_EN
  logic [CntW-1:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  issue_scoreboard #(.PERF_CNT_W(CntW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_dec_valid   (dec_valid),
    .i_uop         (uop),
    .i_dec_pc      (dec_pc),
    .o_dec_ready   (dec_ready),
    .o_ex_valid    (ex_valid),
    .o_ex_uop      (ex_uop),
    .o_ex_pc       (ex_pc),
    .i_ex_ready    (ex_ready),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd),
    .i_flush       (flush),
    .o_stall_to_dec(stall_to_dec),
    .o_busy_regs   (busy_regs)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  function automatic uop_t mk_uop(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic u1, input logic u2,
                                  input logic wr, input logic [31:0] imm);
    uop_t u;
    u           = '0;
    u.valid     = 1'b1;
    u.opcode    = 7'h13;
    u.rd        = rd;
    u.rs1       = rs1;
    u.rs2       = rs2;
    u.uses_rs1  = u1;
    u.uses_rs2  = u2;
    u.writes_rd = wr;
    u.imm       = imm;
    return u;
  endfunction

  task automatic idle_inputs();
    dec_valid = 1'b0;
    uop       = '0;
    dec_pc    = 32'd0;
    ex_ready  = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    flush     = 1'b0;
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+4.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid);
    end
    n_tests++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready);
    end
    n_tests++;
    if (stall_to_dec !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall_to_dec);
    end
    n_tests++;
    if (busy_regs !== 32'd0) begin
      n_fail++; $display("FAIL reset_busy: got %h want 0", busy_regs);
    end
`ifdef ISSUE_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  // ADDI x5: accept c0, issue c1, busy[5] visible c2.
  task automatic test_addi_issue();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 32'd7);
    dec_pc    = 32'h100;
    settle();
    n_tests++;
    if (dec_ready !== 1'b1 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL addi_c0: got ready=%b ex_valid=%b want 1/0", dec_ready, ex_valid);
    end
    next_cycle();
    dec_valid = 1'b0;
    settle();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_uop.rd !== 5'd5) begin
      n_fail++;
      $display("FAIL addi_c1_issue: got valid=%b pc=%h rd=%0d want 1/100/5",
               ex_valid, ex_pc, ex_uop.rd);
    end
    n_tests++;
    if (busy_regs !== 32'd0) begin
      n_fail++; $display("FAIL addi_c1_busy: got %h want 0", busy_regs);
    end
    next_cycle();
    settle();
    n_tests++;
    if (busy_regs !== 32'h0000_0020 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL addi_c2: got busy=%h ex_valid=%b want 00000020/0",
                         busy_regs, ex_valid);
    end
  endtask

  // ADD x6,x5,x1 waits on x5 until the writeback of x5 releases it.
  task automatic test_raw_hazard();
    test_addi_issue();
    next_cycle();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 32'd0);
    dec_pc    = 32'h104;
    next_cycle();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h108;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (ex_valid !== 1'b0 || stall_to_dec !== 1'b1) begin
        n_fail++; $display("FAIL raw_stall_%0d: got ex_valid=%b stall=%b want 0/1",
                           i, ex_valid, stall_to_dec);
      end
      next_cycle();
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    settle();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || stall_to_dec !== 1'b0) begin
      n_fail++; $display("FAIL raw_release: got valid=%b pc=%h stall=%b want 1/104/0",
                         ex_valid, ex_pc, stall_to_dec);
    end
    next_cycle();
    idle_inputs();
    settle();
    n_tests++;
    if (busy_regs !== 32'h0000_0040) begin
      n_fail++; $display("FAIL raw_busy_after: got %h want 00000040", busy_regs);
    end
  endtask

  // Three cycles of EX backpressure on a hazard-free uop.
  task automatic test_backpressure();
    do_reset();
    ex_ready  = 1'b0;
    dec_valid = 1'b1;
    uop       = mk_uop(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1);
    dec_pc    = 32'h200;
    next_cycle();
    dec_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (ex_valid !== 1'b0 || stall_to_dec !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall_%0d: got ex_valid=%b stall=%b want 0/1",
                           i, ex_valid, stall_to_dec);
      end
      next_cycle();
    end
    ex_ready = 1'b1;
    settle();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin
      n_fail++; $display("FAIL bp_issue: got valid=%b pc=%h want 1/200", ex_valid, ex_pc);
    end
`ifdef ISSUE_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  // Flush drops the held uop but leaves pending bits alone.
  task automatic test_flush();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h300;
    next_cycle();
    uop       = mk_uop(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h304;
    next_cycle();
    dec_valid = 1'b1;
    flush     = 1'b1;
    settle();
    n_tests++;
    if (ex_valid !== 1'b0 || dec_ready !== 1'b0 || stall_to_dec !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle: got valid=%b ready=%b stall=%b want 0/0/1",
                         ex_valid, dec_ready, stall_to_dec);
    end
    n_tests++;
    if (busy_regs !== 32'h0000_0010) begin
      n_fail++; $display("FAIL flush_busy_now: got %h want 00000010", busy_regs);
    end
    next_cycle();
    idle_inputs();
    settle();
    n_tests++;
    if (ex_valid !== 1'b0 || dec_ready !== 1'b1 || busy_regs !== 32'h0000_0010) begin
      n_fail++; $display("FAIL flush_after: got valid=%b ready=%b busy=%h want 0/1/00000010",
                         ex_valid, dec_ready, busy_regs);
    end
  endtask

  // Issue of an x7 writer in the same cycle x7 retires keeps x7 pending.
  task automatic test_set_release();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h400;
    next_cycle();
    dec_pc    = 32'h404;
    next_cycle();
    dec_valid = 1'b0;
    wb_valid  = 1'b1;
    wb_rd     = 5'd7;
    settle();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h404) begin
      n_fail++; $display("FAIL setrel_issue: got valid=%b pc=%h want 1/404", ex_valid, ex_pc);
    end
    next_cycle();
    wb_valid = 1'b1;
    wb_rd    = 5'd12;
    settle();
    n_tests++;
    if (busy_regs !== 32'h0000_0080) begin
      n_fail++; $display("FAIL setrel_busy: got %h want 00000080", busy_regs);
    end
    next_cycle();
    idle_inputs();
    settle();
    n_tests++;
    if (busy_regs !== 32'h0000_0080) begin
      n_fail++; $display("FAIL spurious_wb: got %h want 00000080", busy_regs);
    end
  endtask

  // x0 as source and destination never creates a dependency.
  task automatic test_x0();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    dec_pc    = 32'h500;
    next_cycle();
    dec_pc    = 32'h504;
    next_cycle();
    dec_valid = 1'b0;
    settle();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || stall_to_dec !== 1'b0) begin
      n_fail++; $display("FAIL x0_b2b: got valid=%b pc=%h stall=%b want 1/504/0",
                         ex_valid, ex_pc, stall_to_dec);
    end
    next_cycle();
    settle();
    n_tests++;
    if (busy_regs !== 32'd0) begin
      n_fail++; $display("FAIL x0_busy: got %h want 0", busy_regs);
    end
  endtask

  // A uop with valid=0 is handshaken but never issued.
  task automatic test_invalid_uop();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    uop.valid = 1'b0;
    dec_pc    = 32'h600;
    settle();
    n_tests++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL inv_ready: got %b want 1", dec_ready);
    end
    next_cycle();
    dec_valid = 1'b0;
    settle();
    n_tests++;
    if (ex_valid !== 1'b0 || dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL inv_not_held: got valid=%b ready=%b want 0/1", ex_valid, dec_ready);
    end
  endtask

  // Reset in mid-cycle clears the held uop and pending bits at once.
  task automatic test_async_reset();
    do_reset();
    dec_valid = 1'b1;
    uop       = mk_uop(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h700;
    next_cycle();
    uop       = mk_uop(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    dec_pc    = 32'h704;
    next_cycle();
    dec_valid = 1'b0;
    ex_ready  = 1'b0;
    settle();
    n_tests++;
    if (busy_regs !== 32'h0000_0008 || stall_to_dec !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got busy=%h stall=%b want 00000008/1",
                         busy_regs, stall_to_dec);
    end
    ex_ready = 1'b1;
    rst_n    = 1'b0;
    #1;
    n_tests++;
    if (busy_regs !== 32'd0 || ex_valid !== 1'b0 || dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_now: got busy=%h valid=%b ready=%b want 0/0/1",
                         busy_regs, ex_valid, dec_ready);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Reference model: at most one waiting uop (queue) and a pending set (array).
  uop_t            m_uop_q[$];
  logic [31:0]     m_pc_q[$];
  bit              m_busy[32];
  logic [CntW-1:0] m_cnt;

  function automatic bit reg_blocked(input logic [4:0] r, input bit wbv, input logic [4:0] wbr);
    return (r != 5'd0) && m_busy[r] && !(wbv && (wbr == r));
  endfunction

  task automatic test_random();
    uop_t        cur, exp_uop;
    bit          blocked, exp_issue, exp_ready;
    logic [31:0] exp_pc, exp_busy;
    do_reset();
    m_uop_q.delete();
    m_pc_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      uop = mk_uop(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom);
      uop.opcode = 7'($urandom);
      uop.valid  = ($urandom_range(0, 9) != 0);
      dec_pc     = $urandom;
      ex_ready   = ($urandom_range(0, 3) != 0);
      wb_valid   = ($urandom_range(0, 2) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 19) == 0);
      settle();

      blocked = 1'b0;
      if (m_uop_q.size() != 0) begin
        cur = m_uop_q[0];
        blocked = (cur.uses_rs1  && reg_blocked(cur.rs1, wb_valid, wb_rd)) ||
                  (cur.uses_rs2  && reg_blocked(cur.rs2, wb_valid, wb_rd)) ||
                  (cur.writes_rd && reg_blocked(cur.rd,  wb_valid, wb_rd));
      end
      exp_issue = (m_uop_q.size() != 0) && !blocked && ex_ready && !flush;
      exp_ready = !flush && ((m_uop_q.size() == 0) || exp_issue);
      exp_uop   = exp_issue ? m_uop_q[0] : '0;
      exp_pc    = exp_issue ? m_pc_q[0] : 32'd0;
      for (int r = 0; r < 32; r++) exp_busy[r] = m_busy[r];

      n_tests++;
      if (ex_valid !== exp_issue || ex_uop !== exp_uop || ex_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL rand_issue cyc%0d: got v=%b uop=%h pc=%h want v=%b uop=%h pc=%h",
                 cyc, ex_valid, ex_uop, ex_pc, exp_issue, exp_uop, exp_pc);
      end
      n_tests++;
      if (dec_ready !== exp_ready || stall_to_dec !== !exp_ready) begin
        n_fail++; $display("FAIL rand_ready cyc%0d: got ready=%b stall=%b want ready=%b",
                           cyc, dec_ready, stall_to_dec, exp_ready);
      end
      n_tests++;
      if (busy_regs !== exp_busy) begin
        n_fail++; $display("FAIL rand_busy cyc%0d: got %h want %h", cyc, busy_regs, exp_busy);
      end
`ifdef ISSUE_PERF_CNT_EN
      n_tests++;
      if (stall_cnt !== m_cnt) begin
        n_fail++; $display("FAIL rand_stall_cnt cyc%0d: got %0d want %0d", cyc, stall_cnt, m_cnt);
      end
`endif

      // Advance the model to the next cycle.
      if ((m_uop_q.size() != 0) && !exp_issue && !flush && (m_cnt != '1)) m_cnt++;
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (exp_issue && exp_uop.writes_rd && (exp_uop.rd != 5'd0)) m_busy[exp_uop.rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (exp_issue || flush) begin
        m_uop_q.delete();
        m_pc_q.delete();
      end
      if (dec_valid && exp_ready && uop.valid) begin
        m_uop_q.push_back(uop);
        m_pc_q.push_back(dec_pc);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_addi_issue();
    test_raw_hazard();
    test_backpressure();
    test_flush();
    test_set_release();
    test_x0();
    test_invalid_uop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter: PERF_CNT_W, 32, width of the stall performance counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_dec_valid  input  1  decode presents a valid uop.
REQ-005 i_uop  input  uop_t  decoded micro-op from riscv_uop_pkg; uses rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd.
REQ-006 i_dec_pc  input  32  PC of the presented uop.
REQ-007 o_dec_ready  output  1  issue stage accepts the presented uop this cycle.
REQ-008 o_ex_valid  output  1  held uop is issued to EX this cycle.
REQ-009 o_ex_uop  output  uop_t  issued uop.
REQ-010 o_ex_pc  output  32  PC of issued uop.
REQ-011 i_ex_ready  input  1  EX can accept a uop this cycle.
REQ-012 i_wb_valid  input  1  one previously issued register-writing uop retires this cycle.
REQ-013 i_wb_rd  input  5  destination register of the retiring uop.
REQ-014 i_flush  input  1  kill all not-yet-issued work.
REQ-015 o_stall_to_dec  output  1  decode must hold its current uop.
REQ-016 o_busy_regs  output  32  current scoreboard pending bits (debug).
REQ-017 o_stall_cnt  output  PERF_CNT_W  stall-cycle counter (present only when ISSUE_PERF_CNT_EN defined).

Function
REQ-018 Block SHALL contain one holding register (uop, pc, held flag) and a 32-bit pending vector pend[31:0]; pend[0] SHALL always read 0.
REQ-019 FSM states EMPTY (held=0) and HELD (held=1); EMPTY->HELD on accept; HELD->EMPTY on issue without accept; HELD->HELD on issue with accept or on hazard/backpressure; any->EMPTY on i_flush.
REQ-020 Release mask rel = i_wb_valid ? onehot(i_wb_rd) : 0; effective pending eff = pend & ~rel (same-cycle writeback release).
REQ-021 hazard = (uses_rs1 && rs1!=0 && eff[rs1]) || (uses_rs2 && rs2!=0 && eff[rs2]) || (writes_rd && rd!=0 && eff[rd]), evaluated on the held uop.
REQ-022 issue = held && !hazard && i_ex_ready && !i_flush; o_ex_valid = issue; o_ex_uop/o_ex_pc driven from holding register, zero when !issue.
REQ-023 Latency: uop accepted in cycle N is issued no earlier than cycle N+1.
REQ-024 o_dec_ready = !i_flush && (!held || issue); accept = i_dec_valid && o_dec_ready; o_stall_to_dec = !o_dec_ready.
REQ-025 On issue with writes_rd && rd!=0, pend[rd] SHALL set next cycle.
REQ-026 Next pend = (pend & ~rel) | set; a simultaneous set and release of the same register SHALL leave the bit set.
REQ-027 i_wb_valid for a register whose bit is clear SHALL be ignored (no error).
REQ-028 i_flush SHALL drop the held uop and block accept that cycle; pend SHALL be unaffected (in-flight uops still retire).
REQ-029 i_dec_valid with invalid uop (i_uop.valid=0) SHALL NOT be accepted-as-held; ready still asserted.

Reset
REQ-030 On rst_n low: held=0, holding register=0, pend=0, o_stall_cnt=0; outputs o_ex_valid=0, o_dec_ready=1, o_stall_to_dec=0, o_busy_regs=0.
REQ-031 Reset asserted mid-operation SHALL discard held uop and all pending bits immediately (asynchronously).

Configuration
REQ-032 Macro ISSUE_PERF_CNT_EN: when defined, o_stall_cnt increments by 1 each cycle held && !issue && !i_flush, saturating at all-ones; when undefined, port and counter are absent.

Verification
REQ-033 Accept ADDI x5 at cycle 0, i_ex_ready=1 -> o_ex_valid=1 cycle 1, o_busy_regs[5]=1 cycle 2.
REQ-034 ADD x6,x5,x1 held while pend[5]=1 -> o_stall_to_dec=1 each cycle; i_wb_valid rd=5 -> issues that same cycle.
REQ-035 i_ex_ready=0 for 3 cycles with held hazard-free uop -> no issue, stall 3 cycles, issue on 4th; ISSUE_PERF_CNT_EN o_stall_cnt=3.
REQ-036 i_flush while HELD -> o_ex_valid=0, next cycle held=0, o_busy_regs unchanged.
REQ-037 Issue writing x7 while i_wb_valid rd=7 same cycle -> o_busy_regs[7]=1 next cycle.
REQ-038 Uop with rd=x0, rs1=x0 -> never stalls on x0, o_busy_regs[0] stays 0.
